// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encodings shared by the stopwatch control, LED and display blocks
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;
  function automatic logic is_running(input sw_state_t s);
    return s == RUN || s == LAP;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle press pulse; prior sample resets high so a button held through reset gives no pulse
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b1;
    else q <= in;
  assign pulse = in & ~q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencing with long-press global clear on lap/reset
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLKFREQ      = 1000,
  parameter int LONGPRESS_MS = 1000,
  parameter int LPCYC        = LONGPRESS_MS * CLKFREQ / 1000,
  parameter int LPBITS       = $clog2(LPCYC + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic       run_en,
  output logic       freeze,
  output logic       clear,
  output logic [1:0] state
);
  sw_state_t state_q, state_d, ss_next, lr_next;
  logic [LPBITS-1:0] lp_cnt_q, lp_cnt_d;
  logic ss_press, lr_press, lp_fire;
  logic run_en_q, run_en_d, freeze_q, freeze_d, clear_q, clear_d;

  rise_detect u_ss (.clk(clk), .rst_n(rst_n), .in(start_stop), .pulse(ss_press));
  rise_detect u_lr (.clk(clk), .rst_n(rst_n), .in(lap_reset),  .pulse(lr_press));

  // Counter saturates at LPCYC so the fire compare at LPCYC-1 matches once per hold
  always_comb begin
    lp_fire  = lap_reset && lp_cnt_q == LPBITS'(LPCYC - 1);
    lp_cnt_d = !lap_reset ? '0 : lp_cnt_q == LPBITS'(LPCYC) ? lp_cnt_q : lp_cnt_q + 1'b1;
    ss_next  = is_running(state_q) ? PAUSE : RUN;
    lr_next  = state_q == RUN ? LAP : state_q == LAP ? RUN : IDLE;
    state_d  = lp_fire ? IDLE : ss_press ? ss_next : lr_press ? lr_next : state_q;
    clear_d  = lp_fire || (!ss_press && lr_press && state_q == PAUSE);
    run_en_d = is_running(state_d);
    freeze_d = state_d == LAP;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      lp_cnt_q <= '0;
      run_en_q <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lp_cnt_q <= lp_cnt_d;
      run_en_q <= run_en_d;
      freeze_q <= freeze_d;
      clear_q  <= clear_d;
    end

  assign state  = state_q;
  assign run_en = run_en_q;
  assign freeze = freeze_q;
  assign clear  = clear_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch. It takes the debounced start/stop and lap/reset button levels and sequences the time-count datapath through run, pause, lap-freeze and clear. It sits between the per-button debounce instances and the counter/display logic. It also detects a long press on lap/reset, which acts as a global clear.

## Interface
Parameters:
- `CLKFREQ`, 1000: clock frequency in Hz.
- `LONGPRESS_MS`, 1000: hold time on lap/reset that triggers a global clear.
- `LPCYC`, `LONGPRESS_MS*CLKFREQ/1000`: long-press length in cycles. Must be ≥ 2.
- `LPBITS`, `$clog2(LPCYC+1)`: long-press counter width.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: debounced level, synchronous to `clk`, high = pressed.
- `lap_reset` in 1: debounced level, synchronous to `clk`, high = pressed.
- `run_en` out 1: count-enable level to the time counter.
- `freeze` out 1: display hold level. Display shows the latched lap time while high.
- `clear` out 1: one-cycle pulse that zeroes the time counter.
- `state` out 2: encoded FSM state for status LEDs.

## Operation
- Press detection: `ss_press = start_stop & ~ss_q` and `lr_press = lap_reset & ~lr_q`, where `ss_q`/`lr_q` are the previous-cycle samples.
- `ss_q` and `lr_q` reset to 1. A button held through reset produces no press until it is released and pressed again.
- States, `state` encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- IDLE:
  - `ss_press` → RUN.
  - `lr_press` is ignored.
- RUN:
  - `ss_press` → PAUSE.
  - `lr_press` → LAP.
- LAP (counter keeps running, display frozen):
  - `ss_press` → PAUSE (freeze released).
  - `lr_press` → RUN.
- PAUSE:
  - `ss_press` → RUN.
  - `lr_press` → IDLE with `clear` pulse.
- Simultaneous `ss_press` and `lr_press`: `ss_press` wins and `lr_press` is discarded. It is not deferred.
- Long press:
  - `lp_cnt` increments on every cycle `lap_reset` is high. It saturates at `LPCYC` and returns to 0 on any cycle `lap_reset` is low.
  - When `lp_cnt` reaches `LPCYC-1` while `lap_reset` is high (the `LPCYC`-th consecutive high sample), from any state: go to IDLE and pulse `clear`.
  - Long press has priority over `ss_press`.
  - It fires exactly once per hold; saturation blocks any re-fire.
- Output decode, all registered:
  - `run_en` = state ∈ {RUN, LAP}.
  - `freeze` = (state == LAP).
  - `clear` = 1 only on the cycle after a transition into IDLE caused by PAUSE+`lr_press` or by long press. This includes a long press while already in IDLE.
- Reset values: state=IDLE, `run_en`=0, `freeze`=0, `clear`=0, `lp_cnt`=0, `ss_q`=`lr_q`=1.
- Asserting `rst_n` mid-hold discards any partial long-press count.

## Timing
- Latency: an input first sampled high at edge k updates state and outputs at edge k. They are visible in cycle k+1.
- `clear` is high for exactly one cycle and coincides with the first cycle `state`=IDLE.
- In the same cycle as `clear`: `run_en`=0 and `freeze`=0.
- Minimum press-to-press spacing is 2 cycles, because each press needs one low sample before it.
- A short press in RUN enters LAP immediately. If the same hold reaches `LPCYC`, the FSM goes LAP → IDLE with `clear`.
- Reset deassertion: no output changes on the first edge unless a fresh press edge occurs.

## Structure
- Package `stopwatch_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t`.
  - The state encodings, shared with the LED and display blocks.
- Sub-module `rise_detect` (`clk`, `rst_n`, `in`, `pulse`): previous-sample register reset to 1, output `in & ~q`. Instantiated twice.
- The long-press counter and FSM live in `stopwatch_ctrl`, with one `always_ff` for state, counter and outputs.

## Test plan
All scenarios use `CLKFREQ`=1000 and `LONGPRESS_MS`=10, so `LPCYC`=10.
- Basic run/pause: release reset, pulse `start_stop` high for 3 cycles → `state`=1, `run_en`=1. Release, press again → `state`=2, `run_en`=0, `clear`=0.
- Lap toggle: in RUN, press `lap_reset` for 3 cycles → `state`=3, `freeze`=1, `run_en`=1. Press again → `state`=1, `freeze`=0.
- Clear from pause: in PAUSE, press `lap_reset` → `state`=0 and a single-cycle `clear`=1. A further press in IDLE → no `clear`.
- Long press: in RUN, hold `lap_reset` for 15 cycles → LAP after 1 cycle, IDLE plus one `clear` pulse after the 10th high sample, no second pulse through cycle 15.
- Simultaneous press: in RUN, raise both inputs on the same edge → `state`=2 (PAUSE). After 9 more held cycles, the long press fires → `state`=0, `clear`=1.
- Reset with held button: hold `start_stop` high through `rst_n` deassertion → stays IDLE. Release then press → RUN. Assert `rst_n` mid-long-press → all outputs 0 asynchronously and the count restarts.
